// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: core fetch/data request ports and bus master port of mem_arbiter.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        flush;
    logic        stallreq_if;
    logic        stallreq_mem;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;
    modport master (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel, flush,
               bus_rdata, bus_ack,
        output if_rdata, if_ready, mem_rdata, mem_ready, stallreq_if, stallreq_mem,
               bus_req, bus_we, bus_addr, bus_wdata, bus_sel, bus_err
    );
    modport slave (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel, flush,
               bus_rdata, bus_ack,
        input  if_rdata, if_ready, mem_rdata, mem_ready, stallreq_if, stallreq_mem,
               bus_req, bus_we, bus_addr, bus_wdata, bus_sel, bus_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding bus arbiter between fetch and data ports, data first,
// with flush draining and a watchdog that aborts unacknowledged bus cycles.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input logic            clk,
    input logic            rst,
    mem_arbiter_if.master  io
);
    typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_MEM, DRAIN_IF, RESP_IF, RESP_MEM} state_t;
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);
    state_t     state, nxt;
    logic [7:0] wd;
    logic       in_bus, done;
    assign in_bus          = state inside {BUSY_IF, BUSY_MEM, DRAIN_IF};
    // an ack on the limit cycle wins over the timeout
    assign io.bus_err      = in_bus && !io.bus_ack && wd == LIMIT;
    assign done            = io.bus_ack || io.bus_err;
    assign io.bus_req      = in_bus;
    assign io.if_ready     = state == RESP_IF && !io.flush;
    assign io.mem_ready    = state == RESP_MEM;
    assign io.stallreq_if  = io.if_req & ~io.if_ready;
    assign io.stallreq_mem = io.mem_req & ~io.mem_ready;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = io.mem_req ? BUSY_MEM : (io.if_req && !io.flush) ? BUSY_IF : IDLE;
            BUSY_IF:  nxt = done ? (io.flush ? IDLE : RESP_IF) : io.flush ? DRAIN_IF : BUSY_IF;
            BUSY_MEM: nxt = done ? RESP_MEM : BUSY_MEM;
            DRAIN_IF: nxt = done ? IDLE : DRAIN_IF;
            default:  nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            wd           <= 8'd0;
            io.bus_we    <= 1'b0;
            io.bus_addr  <= 32'd0;
            io.bus_wdata <= 32'd0;
            io.bus_sel   <= 4'd0;
            io.if_rdata  <= 32'd0;
            io.mem_rdata <= 32'd0;
        end else begin
            state <= nxt;
            // any state change into a bus state, including BUSY_IF -> DRAIN_IF, restarts the watchdog
            wd <= (in_bus && nxt == state) ? wd + 8'd1 : 8'd0;
            if (state == IDLE && nxt == BUSY_MEM) begin
                io.bus_we    <= io.mem_we;
                io.bus_addr  <= io.mem_addr;
                io.bus_wdata <= io.mem_wdata;
                io.bus_sel   <= io.mem_sel;
            end else if (state == IDLE && nxt == BUSY_IF) begin
                io.bus_we    <= 1'b0;
                io.bus_addr  <= io.if_addr;
                io.bus_wdata <= 32'd0;
                io.bus_sel   <= 4'hF;
            end
            if (state == BUSY_IF && nxt == RESP_IF)
                io.if_rdata <= io.bus_ack ? io.bus_rdata : 32'd0;
            if (state == BUSY_MEM && nxt == RESP_MEM)
                io.mem_rdata <= io.bus_ack ? io.bus_rdata : 32'd0;
        end
    end
endmodule
